// File: rtl/dma_timing_control_mc_if.sv
// Bus-side signal bundle of the multi-channel DMA timing controller.
// slave = controller side, master = requester/bus-master side.
interface dma_timing_control_mc_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  // HRQ/HLDA handshake: the controller raises HRQ from SO and holds it through S4;
  // a grant is taken only in a cycle where HRQ=1 and HLDA=1 are both seen in SO,
  // and HRQ stays high until the state returns to SI regardless of HLDA.
  logic [NCH-1:0]   DREQ;
  logic [NCH-1:0]   DACK;
  logic             HRQ;
  logic             HLDA;
  logic             READY;
  logic             EOP_N;
  logic             EOP_N_OUT;
  logic             RD_N;
  logic             WR_N;
  logic             cnt_load;
  logic [SEL_W-1:0] cnt_sel;
  logic [CNT_W-1:0] cnt_data;
  logic [5:0]       state;
  logic [SEL_W-1:0] cur_ch;

  modport slave (
    input  DREQ, HLDA, READY, EOP_N, cnt_load, cnt_sel, cnt_data,
    output DACK, HRQ, EOP_N_OUT, RD_N, WR_N, state, cur_ch
  );

  modport master (
    output DREQ, HLDA, READY, EOP_N, cnt_load, cnt_sel, cnt_data,
    input  DACK, HRQ, EOP_N_OUT, RD_N, WR_N, state, cur_ch
  );
endinterface

// File: rtl/dma_timing_control_mc.sv
// Multi-channel DMA timing controller: DREQ arbitration, HRQ/HLDA handshake,
// one-hot SI/SO/S1..S4 sequencing, per-channel word counts with TC and abort.
module dma_timing_control_mc #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 16,
  parameter int ROTATE_PRIO = 0,
  parameter int DEMAND_MODE = 0,
  parameter int AUTOINIT    = 0
) (
  input logic                   CLK,
  input logic                   RESET,
  dma_timing_control_mc_if.slave bus
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [5:0] {
    ST_SI = 6'b000001,
    ST_SO = 6'b000010,
    ST_S1 = 6'b000100,
    ST_S2 = 6'b001000,
    ST_S3 = 6'b010000,
    ST_S4 = 6'b100000
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [NCH-1:0]   r_mask;
  logic [NCH-1:0]   r_dack;
  logic [CNT_W-1:0] r_cnt  [NCH];
  logic [CNT_W-1:0] r_base [NCH];
  logic [SEL_W-1:0] r_cur_ch;
  logic [SEL_W-1:0] r_ptr;
  logic             r_hrq;
  logic             r_rd_n;
  logic             r_wr_n;
  logic             r_eop_out;

  logic [NCH-1:0]   w_elig;
  logic             w_any;
  logic             w_tc;
  logic             w_grant;
  logic             w_load;
  logic             w_xfer;
  logic             w_write;
  logic [SEL_W-1:0] w_winner;
  logic [SEL_W-1:0] w_ch_next;
  int               w_start;

  assign w_elig  = bus.DREQ & ~r_mask;
  assign w_any   = |w_elig;
  assign w_tc    = (r_cnt[r_cur_ch] == '0);
  assign w_start = (ROTATE_PRIO != 0) ? int'(r_ptr) + 1 : 0;

  // Walk from the farthest offset down so the nearest eligible channel to w_start wins.
  always_comb begin
    w_winner = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_elig[SEL_W'((w_start + k) % NCH)]) w_winner = SEL_W'((w_start + k) % NCH);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SI: if (w_any) w_next = ST_SO;
      ST_SO: begin
        if (bus.HLDA && w_any) w_next = ST_S1;
        else if (!w_any)       w_next = ST_SI;
      end
      ST_S1: w_next = ST_S2;
      ST_S2: w_next = ST_S3;
      ST_S3: if (bus.READY) w_next = ST_S4;
      ST_S4: w_next = (DEMAND_MODE != 0 && !w_tc && bus.DREQ[r_cur_ch]) ? ST_S1 : ST_SI;
      default: w_next = ST_SI;
    endcase
    if (!bus.EOP_N) w_next = ST_SI;
  end

  assign w_grant   = (r_state == ST_SO) && (w_next == ST_S1);
  assign w_ch_next = w_grant ? w_winner : r_cur_ch;
  assign w_load    = bus.cnt_load && (r_state == ST_SI) && (w_next == ST_SI);
  assign w_xfer    = (w_next == ST_S2) || (w_next == ST_S3) || (w_next == ST_S4);
  assign w_write   = (w_next == ST_S3) || (w_next == ST_S4);

  // Outputs are computed from the next state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_SI;
      r_hrq     <= 1'b0;
      r_dack    <= '0;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_eop_out <= 1'b1;
      r_cur_ch  <= '0;
      r_ptr     <= '0;
      r_mask    <= '1;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]  <= '0;
        r_base[i] <= '0;
      end
    end else begin
      r_state   <= w_next;
      r_hrq     <= (w_next != ST_SI);
      r_dack    <= w_xfer ? (NCH'(1) << w_ch_next) : '0;
      r_rd_n    <= !w_xfer;
      r_wr_n    <= !w_write;
      r_eop_out <= !((w_next == ST_S4) && w_tc);
      if (w_grant) r_cur_ch <= w_winner;
      // Every S4 cycle is a completed transfer, even when EOP_N aborts it.
      if (r_state == ST_S4) begin
        r_ptr <= r_cur_ch;
        if (w_tc && AUTOINIT != 0) r_cnt[r_cur_ch] <= r_base[r_cur_ch];
        else                       r_cnt[r_cur_ch] <= r_cnt[r_cur_ch] - CNT_W'(1);
        if (w_tc && AUTOINIT == 0) r_mask[r_cur_ch] <= 1'b1;
      end
      if (w_load) begin
        r_base[bus.cnt_sel] <= bus.cnt_data;
        r_cnt[bus.cnt_sel]  <= bus.cnt_data;
        r_mask[bus.cnt_sel] <= 1'b0;
      end
    end
  end

  assign bus.state     = r_state;
  assign bus.HRQ       = r_hrq;
  assign bus.DACK      = r_dack;
  assign bus.RD_N      = r_rd_n;
  assign bus.WR_N      = r_wr_n;
  assign bus.EOP_N_OUT = r_eop_out;
  assign bus.cur_ch    = r_cur_ch;
endmodule

// File: tb/tb_dma_timing_control_mc.sv
// Directed bench for dma_timing_control_mc: four instances cover the default,
// demand, rotating-priority and autoinitialise configurations.
module tb_dma_timing_control_mc;
  localparam logic [5:0] SI = 6'b000001;
  localparam logic [5:0] SO = 6'b000010;
  localparam logic [5:0] S1 = 6'b000100;
  localparam logic [5:0] S2 = 6'b001000;
  localparam logic [5:0] S3 = 6'b010000;
  localparam logic [5:0] S4 = 6'b100000;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  dma_timing_control_mc_if #(.NCH(4), .CNT_W(16)) i0 ();
  dma_timing_control_mc_if #(.NCH(4), .CNT_W(16)) i1 ();
  dma_timing_control_mc_if #(.NCH(4), .CNT_W(16)) i2 ();
  dma_timing_control_mc_if #(.NCH(4), .CNT_W(16)) i3 ();

  dma_timing_control_mc #(.NCH(4), .CNT_W(16), .ROTATE_PRIO(0), .DEMAND_MODE(0), .AUTOINIT(0))
    d0 (.CLK(CLK), .RESET(RESET), .bus(i0));
  dma_timing_control_mc #(.NCH(4), .CNT_W(16), .ROTATE_PRIO(0), .DEMAND_MODE(1), .AUTOINIT(0))
    d1 (.CLK(CLK), .RESET(RESET), .bus(i1));
  dma_timing_control_mc #(.NCH(4), .CNT_W(16), .ROTATE_PRIO(1), .DEMAND_MODE(0), .AUTOINIT(0))
    d2 (.CLK(CLK), .RESET(RESET), .bus(i2));
  dma_timing_control_mc #(.NCH(4), .CNT_W(16), .ROTATE_PRIO(0), .DEMAND_MODE(0), .AUTOINIT(1))
    d3 (.CLK(CLK), .RESET(RESET), .bus(i3));

  // Expected {state, HRQ, DACK, RD_N, WR_N, EOP_N_OUT} for a given state.
  function automatic logic [13:0] exp_vec(input logic [5:0] s, input logic [3:0] oh,
                                          input logic eop_n);
    logic xfer, wr;
    xfer = (s == S2) || (s == S3) || (s == S4);
    wr   = (s == S3) || (s == S4);
    return {s, (s != SI), (xfer ? oh : 4'b0000), !xfer, !wr, eop_n};
  endfunction

  // One clock; the bus master answers HRQ with HLDA one cycle later.
  task automatic tick;
    @(posedge CLK);
    #1;
    i0.HLDA = i0.HRQ;
    i1.HLDA = i1.HRQ;
    i2.HLDA = i2.HRQ;
    i3.HLDA = i3.HRQ;
  endtask

  task automatic init_inputs;
    i0.DREQ = '0; i0.HLDA = 0; i0.READY = 1; i0.EOP_N = 1; i0.cnt_load = 0; i0.cnt_sel = '0; i0.cnt_data = '0;
    i1.DREQ = '0; i1.HLDA = 0; i1.READY = 1; i1.EOP_N = 1; i1.cnt_load = 0; i1.cnt_sel = '0; i1.cnt_data = '0;
    i2.DREQ = '0; i2.HLDA = 0; i2.READY = 1; i2.EOP_N = 1; i2.cnt_load = 0; i2.cnt_sel = '0; i2.cnt_data = '0;
    i3.DREQ = '0; i3.HLDA = 0; i3.READY = 1; i3.EOP_N = 1; i3.cnt_load = 0; i3.cnt_sel = '0; i3.cnt_data = '0;
  endtask

  task automatic test_reset;
    logic [13:0] got;
    RESET = 1'b1;
    repeat (3) tick();
    got = {i0.state, i0.HRQ, i0.DACK, i0.RD_N, i0.WR_N, i0.EOP_N_OUT};
    n_checks++;
    if (got !== {SI, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL reset_outputs: got %b expected %b", got, {SI, 8'b0_0000_111});
    end
    n_checks++;
    if ({i0.cur_ch, d0.r_mask, d0.r_cnt[0], d2.r_ptr} !== {2'd0, 4'hF, 16'd0, 2'd0}) begin
      n_errors++; $display("FAIL reset_regs: cur_ch=%0d mask=%b cnt0=%0d ptr=%0d expected 0 1111 0 0",
                           i0.cur_ch, d0.r_mask, d0.r_cnt[0], d2.r_ptr);
    end
    n_checks++;
    if ({i1.state, i2.state, i3.state} !== {SI, SI, SI}) begin
      n_errors++; $display("FAIL reset_states: got %b %b %b expected %b", i1.state, i2.state, i3.state, SI);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_single;
    logic [5:0] seq [6] = '{SO, S1, S2, S3, S4, SI};
    logic [13:0] got, exp;
    i0.cnt_load = 1; i0.cnt_sel = 2'd0; i0.cnt_data = 16'd2;
    tick();
    i0.cnt_load = 0;
    i0.DREQ = 4'b0001;
    for (int g = 0; g < 3; g++) begin
      for (int p = 0; p < 6; p++) begin
        tick();
        got = {i0.state, i0.HRQ, i0.DACK, i0.RD_N, i0.WR_N, i0.EOP_N_OUT};
        exp = exp_vec(seq[p], 4'b0001, !(g == 2 && p == 4));
        n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL single_seq g%0d p%0d: got %b expected %b", g, p, got, exp);
        end
      end
    end
    n_checks++;
    if ({d0.r_cnt[0], d0.r_mask[0]} !== {16'hFFFF, 1'b1}) begin
      n_errors++; $display("FAIL single_tc: cnt=%h mask=%b expected ffff 1", d0.r_cnt[0], d0.r_mask[0]);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({i0.state, i0.HRQ} !== {SI, 1'b0}) begin
        n_errors++; $display("FAIL single_masked c%0d: state=%b hrq=%b expected %b 0", k, i0.state, i0.HRQ, SI);
      end
    end
    i0.DREQ = '0;
  endtask

  task automatic test_demand;
    logic [5:0] loop_s [4] = '{S1, S2, S3, S4};
    logic [5:0] s;
    logic [13:0] got, exp;
    i1.cnt_load = 1; i1.cnt_sel = 2'd0; i1.cnt_data = 16'd3;
    tick();
    i1.cnt_load = 0;
    i1.DREQ = 4'b0001;
    for (int p = 0; p < 18; p++) begin
      tick();
      s = (p == 0) ? SO : (p == 17) ? SI : loop_s[(p - 1) % 4];
      exp = exp_vec(s, 4'b0001, p != 16);
      got = {i1.state, i1.HRQ, i1.DACK, i1.RD_N, i1.WR_N, i1.EOP_N_OUT};
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL demand_seq p%0d: got %b expected %b", p, got, exp);
      end
    end
    n_checks++;
    if ({d1.r_cnt[0], d1.r_mask[0]} !== {16'hFFFF, 1'b1}) begin
      n_errors++; $display("FAIL demand_tc: cnt=%h mask=%b expected ffff 1", d1.r_cnt[0], d1.r_mask[0]);
    end
    i1.DREQ = '0;
  endtask

  task automatic test_ready;
    logic        rdy [9] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
    logic [5:0]  seq [9] = '{SO, S1, S2, S3, S3, S3, S3, S4, SI};
    logic [13:0] got, exp;
    i0.cnt_load = 1; i0.cnt_sel = 2'd1; i0.cnt_data = 16'd5;
    tick();
    i0.cnt_load = 0;
    i0.DREQ = 4'b0010;
    for (int i = 0; i < 9; i++) begin
      i0.READY = rdy[i];
      tick();
      got = {i0.state, i0.HRQ, i0.DACK, i0.RD_N, i0.WR_N, i0.EOP_N_OUT};
      exp = exp_vec(seq[i], 4'b0010, 1'b1);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL ready_seq s%0d: got %b expected %b", i, got, exp);
      end
    end
    i0.READY = 1;
    i0.DREQ = '0;
    n_checks++;
    if (d0.r_cnt[1] !== 16'd4) begin
      n_errors++; $display("FAIL ready_count: got %0d expected 4", d0.r_cnt[1]);
    end
  endtask

  task automatic test_abort;
    logic [5:0]  tgt [5] = '{SI, SO, S1, S2, S4};
    logic [15:0] exp_cnt = 16'd4;
    bit found;
    i0.DREQ = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      found = 0;
      for (int k = 0; k < 12; k++) begin
        if (i0.state === tgt[c]) begin found = 1; break; end
        tick();
      end
      n_checks++;
      if (!found) begin
        n_errors++; $display("FAIL abort_reach c%0d: state=%b expected %b", c, i0.state, tgt[c]);
      end
      i0.EOP_N = 0;
      tick();
      i0.EOP_N = 1;
      if (tgt[c] == S4) exp_cnt = exp_cnt - 16'd1;
      n_checks++;
      if ({i0.state, i0.HRQ, i0.EOP_N_OUT} !== {SI, 1'b0, 1'b1}) begin
        n_errors++; $display("FAIL abort_state c%0d: state=%b hrq=%b eop_out=%b expected %b 0 1",
                             c, i0.state, i0.HRQ, i0.EOP_N_OUT, SI);
      end
      n_checks++;
      if (d0.r_cnt[1] !== exp_cnt) begin
        n_errors++; $display("FAIL abort_count c%0d: got %0d expected %0d", c, d0.r_cnt[1], exp_cnt);
      end
    end
    i0.DREQ = '0;
    tick();
  endtask

  task automatic test_fixed_prio;
    bit found;
    for (int k = 0; k < 4; k++) begin
      i0.cnt_load = 1; i0.cnt_sel = 2'(k); i0.cnt_data = 16'd5;
      tick();
    end
    i0.cnt_load = 0;
    i0.DREQ = 4'b1111;
    for (int g = 0; g < 3; g++) begin
      found = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (i0.state === S2) begin found = 1; break; end
      end
      n_checks++;
      if (!found || {i0.cur_ch, i0.DACK} !== {2'd0, 4'b0001}) begin
        n_errors++; $display("FAIL fixed_prio g%0d: reached=%0d cur_ch=%0d dack=%b expected 0 0001",
                             g, found, i0.cur_ch, i0.DACK);
      end
    end
    i0.DREQ = '0;
    repeat (4) tick();
    n_checks++;
    if ({i0.state, d0.r_cnt[0], d0.r_cnt[1]} !== {SI, 16'd2, 16'd5}) begin
      n_errors++; $display("FAIL fixed_counts: state=%b cnt0=%0d cnt1=%0d expected %b 2 5",
                           i0.state, d0.r_cnt[0], d0.r_cnt[1], SI);
    end
  endtask

  task automatic test_rotate;
    logic [1:0] order [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] oh;
    bit found;
    for (int k = 0; k < 4; k++) begin
      i2.cnt_load = 1; i2.cnt_sel = 2'(k); i2.cnt_data = 16'd5;
      tick();
    end
    i2.cnt_load = 0;
    i2.DREQ = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (i2.state === S2) begin found = 1; break; end
      end
      oh = 4'b0001 << order[g];
      n_checks++;
      if (!found || {i2.cur_ch, i2.DACK} !== {order[g], oh}) begin
        n_errors++; $display("FAIL rotate_order g%0d: reached=%0d cur_ch=%0d dack=%b expected %0d %b",
                             g, found, i2.cur_ch, i2.DACK, order[g], oh);
      end
    end
    i2.DREQ = '0;
    repeat (4) tick();
  endtask

  task automatic test_autoinit_reset;
    bit found;
    i3.cnt_load = 1; i3.cnt_sel = 2'd0; i3.cnt_data = 16'd1;
    tick();
    i3.cnt_load = 0;
    i3.DREQ = 4'b0001;
    found = 0;
    for (int k = 0; k < 12; k++) begin
      if (i3.state === S3) begin found = 1; break; end
      tick();
    end
    i3.cnt_load = 1; i3.cnt_sel = 2'd0; i3.cnt_data = 16'd7;
    tick();
    i3.cnt_load = 0;
    n_checks++;
    if (!found || {i3.state, i3.EOP_N_OUT, d3.r_cnt[0]} !== {S4, 1'b1, 16'd1}) begin
      n_errors++; $display("FAIL auto_load_ignored: reached=%0d state=%b eop_out=%b cnt=%0d expected %b 1 1",
                           found, i3.state, i3.EOP_N_OUT, d3.r_cnt[0], S4);
    end
    tick();
    n_checks++;
    if ({i3.state, d3.r_cnt[0]} !== {SI, 16'd0}) begin
      n_errors++; $display("FAIL auto_first: state=%b cnt=%0d expected %b 0", i3.state, d3.r_cnt[0], SI);
    end
    found = 0;
    for (int k = 0; k < 12; k++) begin
      if (i3.state === S4) begin found = 1; break; end
      tick();
    end
    n_checks++;
    if (!found || i3.EOP_N_OUT !== 1'b0) begin
      n_errors++; $display("FAIL auto_tc_pulse: reached=%0d eop_out=%b expected 0", found, i3.EOP_N_OUT);
    end
    tick();
    n_checks++;
    if ({i3.state, d3.r_cnt[0], d3.r_mask[0], i3.EOP_N_OUT} !== {SI, 16'd1, 1'b0, 1'b1}) begin
      n_errors++; $display("FAIL auto_reload: state=%b cnt=%0d mask=%b eop_out=%b expected %b 1 0 1",
                           i3.state, d3.r_cnt[0], d3.r_mask[0], i3.EOP_N_OUT, SI);
    end
    found = 0;
    for (int k = 0; k < 12; k++) begin
      if (i3.state === S3) begin found = 1; break; end
      tick();
    end
    RESET = 1'b1;
    tick();
    n_checks++;
    if (!found || {i3.state, i3.HRQ, i3.DACK} !== {SI, 1'b0, 4'b0000}) begin
      n_errors++; $display("FAIL reset_in_s3: reached=%0d state=%b hrq=%b dack=%b expected %b 0 0000",
                           found, i3.state, i3.HRQ, i3.DACK, SI);
    end
    RESET = 1'b0;
    i3.DREQ = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_inputs();
    test_reset();
    test_single();
    test_demand();
    test_ready();
    test_abort();
    test_fixed_prio();
    test_rotate();
    test_autoinit_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
